cart_dl_arbiter: RTL and testbench

CART_DL_ARBITER -- requirements
Module: cart_dl_arbiter

---
 rtl/cart_dl_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_cart_dl_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_dl_arbiter.sv
// cart_dl_arbiter: shares one single-port cartridge RAM between the ioctl
// download loader (writes) and a CPU read port, and tracks download status.
// Optional feature macro: CART_DL_ARBITER_CHECKSUM_EN enables the cart_sum
// accumulator; when undefined cart_sum is tied to zero.
module cart_dl_arbiter #(
  parameter logic [11:0] CART_BASE  = 12'h400,
  parameter int unsigned CART_MAX   = 3072,
  parameter logic [7:0]  CART_INDEX = 8'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_hold,
  output logic        ram_en,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        cart_loaded,
  output logic [11:0] cart_len,
  output logic        cart_ovf,
  output logic [7:0]  cart_sum
);

  localparam int unsigned AW = 25;
  localparam int unsigned RW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 13;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CPU_RD   = 2'd1;
  localparam logic [1:0] S_CPU_DATA = 2'd2;
  localparam logic [1:0] S_DL_WR    = 2'd3;

  logic [1:0]    rst_sync;
  logic          run;
  logic          dl_active;
  logic          dl_active_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          wr_strobe;
  logic          wr_take;
  logic          wr_drop;
  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic          in_range;
  logic          fin_pend;
  logic [LW-1:0] len_cand;
  logic [LW-1:0] len_sat;
  logic [LW-1:0] len_next;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic          ram_en_n;
  logic          ram_we_n;
  logic [RW-1:0] ram_addr_n;
  logic [DW-1:0] ram_wdata_n;
  logic          cpu_ack_n;
  logic          xfer;

  // Reset release synchronizer; assertion stays asynchronous.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run       = rst_sync[1];
  assign dl_active = ioctl_download && (ioctl_index == CART_INDEX);
  assign dl_rise   = run && dl_active && !dl_active_q;
  assign dl_fall   = run && !dl_active && dl_active_q;
  assign wr_strobe = run && dl_active && ioctl_wr;
  assign wr_take   = wr_strobe && !buf_valid;
  assign wr_drop   = wr_strobe && buf_valid;
  assign in_range  = buf_addr < AW'(CART_MAX);
  assign ioctl_wait = buf_valid;

  // Candidate cart_len: max(current, offset+1), saturated at CART_MAX.
  always_comb begin
    len_cand = LW'(buf_addr[RW-1:0]) + LW'(1);
    len_sat  = (len_cand > LW'(CART_MAX)) ? LW'(CART_MAX) : len_cand;
    len_next = (len_sat > LW'(cart_len)) ? len_sat : LW'(cart_len);
  end

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_n     = state;
    ram_en_n    = 1'b0;
    ram_we_n    = 1'b0;
    ram_addr_n  = ram_addr;
    ram_wdata_n = ram_wdata;
    cpu_ack_n   = 1'b0;
    xfer        = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && buf_valid) begin
          state_n = S_DL_WR;
          xfer    = 1'b1;
          if (in_range) begin
            ram_en_n    = 1'b1;
            ram_we_n    = 1'b1;
            ram_addr_n  = CART_BASE + buf_addr[RW-1:0];
            ram_wdata_n = buf_data;
          end
        end else if (run && cpu_req && !cpu_hold && !cpu_ack && !wr_strobe) begin
          state_n    = S_CPU_RD;
          ram_en_n   = 1'b1;
          ram_addr_n = cpu_addr;
        end
      end
      S_CPU_RD:   state_n = S_CPU_DATA;
      S_CPU_DATA: begin
        state_n   = S_IDLE;
        cpu_ack_n = 1'b1;
      end
      S_DL_WR:    state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // State and registered RAM/CPU outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_n;
      ram_en    <= ram_en_n;
      ram_we    <= ram_we_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
      cpu_ack   <= cpu_ack_n;
      if (state == S_CPU_DATA) cpu_rdata <= ram_rdata;
    end
  end

  // One-entry loader buffer; emptied when its byte moves to the write stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (wr_take) begin
      buf_valid <= 1'b1;
      buf_addr  <= ioctl_addr;
      buf_data  <= ioctl_dout;
    end else if (xfer) begin
      buf_valid <= 1'b0;
    end
  end

  // Download edge tracking, CPU hold and cartridge status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_active_q <= 1'b0;
      cpu_hold    <= 1'b0;
      fin_pend    <= 1'b0;
      cart_loaded <= 1'b0;
      cart_len    <= '0;
      cart_ovf    <= 1'b0;
    end else begin
      if (run) dl_active_q <= dl_active;
      if (dl_rise) begin
        cpu_hold    <= 1'b1;
        fin_pend    <= 1'b0;
        cart_loaded <= 1'b0;
        cart_len    <= '0;
        cart_ovf    <= 1'b0;
      end else begin
        if (cpu_hold && !buf_valid && (state == S_IDLE) && !ioctl_download)
          cpu_hold <= 1'b0;
        if (xfer && in_range) cart_len <= RW'(len_next);
        if ((xfer && !in_range) || wr_drop) cart_ovf <= 1'b1;
        if (dl_fall) begin
          fin_pend <= 1'b1;
        end else if (fin_pend && !buf_valid && (state == S_IDLE)) begin
          fin_pend    <= 1'b0;
          cart_loaded <= (cart_len != '0) && !cart_ovf;
        end
      end
    end
  end

`ifdef CART_DL_ARBITER_CHECKSUM_EN
  logic [DW-1:0] sum_q;

  // Modulo-256 sum of every in-range byte written during the download.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              sum_q <= '0;
    else if (dl_rise)          sum_q <= '0;
    else if (xfer && in_range) sum_q <= sum_q + buf_data;
  end

  assign cart_sum = sum_q;
`else
  assign cart_sum = 8'h00;
`endif

endmodule

// File: tb/tb_cart_dl_arbiter.sv
// Scoreboard bench for cart_dl_arbiter: stimulus pushes expected RAM writes
// and CPU read data into queues, a negedge monitor pops and compares them.
module tb_cart_dl_arbiter;

  localparam int unsigned   CART_MAX  = 3072;
  localparam logic [11:0]   CART_BASE = 12'h400;
  localparam logic [7:0]    CART_IDX  = 8'd1;
`ifdef CART_DL_ARBITER_CHECKSUM_EN
  localparam bit            SUM_ON    = 1'b1;
  localparam logic [7:0]    SUM4      = 8'h0A;
`else
  localparam bit            SUM_ON    = 1'b0;
  localparam logic [7:0]    SUM4      = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_req;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_hold;
  logic        ram_en;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        cart_loaded;
  logic [11:0] cart_len;
  logic        cart_ovf;
  logic [7:0]  cart_sum;

  cart_dl_arbiter #(.CART_BASE(CART_BASE), .CART_MAX(CART_MAX), .CART_INDEX(CART_IDX)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_hold(cpu_hold), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .cart_loaded(cart_loaded),
    .cart_len(cart_len), .cart_ovf(cart_ovf), .cart_sum(cart_sum)
  );

  always #5 clk = ~clk;

  // Bench RAM with a backdoor write port for preloading.
  logic [7:0]  ram [4096];
  logic [7:0]  shadow [4096];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] wq[$];
  logic [7:0]  rq[$];

  // Reference status of the cartridge download.
  bit          m_act;
  int          m_len;
  bit          m_ovf;
  logic [7:0]  m_sum;
  bit          m_loaded;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({ioctl_wait, cpu_rdata, cpu_ack, cpu_hold, ram_en, ram_we, ram_addr,
                ram_wdata, cart_loaded, cart_len, cart_ovf, cart_sum});
  endfunction

  function automatic logic [63:0] status();
    return 64'({cart_loaded, cart_len, cart_ovf, cart_sum});
  endfunction

  function automatic logic [63:0] exp_status();
    logic [7:0] s;
    s = SUM_ON ? m_sum : 8'h00;
    return 64'({m_loaded, 12'(m_len), m_ovf, s});
  endfunction

  // Monitor: every RAM write and every CPU ack must match the next expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ram_we) begin
        if (wq.size() == 0) check("unexpected_ram_write", 64'({ram_addr, ram_wdata}), 64'hFFFF_FFFF);
        else check("ram_write", 64'({ram_addr, ram_wdata}), 64'(wq.pop_front()));
      end
      if (cpu_ack) begin
        if (rq.size() == 0) check("unexpected_cpu_ack", 64'(cpu_rdata), 64'hFFFF_FFFF);
        else check("cpu_rdata", 64'(cpu_rdata), 64'(rq.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic model_begin(input logic [7:0] idx);
    m_act = (idx == CART_IDX);
    if (m_act) begin m_len = 0; m_ovf = 0; m_sum = 8'h00; m_loaded = 0; end
  endtask

  task automatic model_push(input logic [24:0] off, input logic [7:0] d);
    logic [11:0] a;
    if (m_act) begin
      if (off < 25'(CART_MAX)) begin
        a = CART_BASE + off[11:0];
        wq.push_back({a, d});
        shadow[a] = d;
        if (int'(off) + 1 > m_len) m_len = int'(off) + 1;
        m_sum = m_sum + d;
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic model_end();
    if (m_act) m_loaded = (m_len > 0) && !m_ovf;
    m_act = 0;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    model_begin(idx);
    tick(1);
  endtask

  task automatic dl_byte(input logic [24:0] off, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 20) begin tick(1); n++; end
    check("ioctl_wait_bound", 64'(n < 20), 64'd1);
    ioctl_addr = off; ioctl_dout = d; ioctl_wr = 1'b1;
    model_push(off, d);
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic dl_end();
    int n = 0;
    ioctl_download = 1'b0;
    while (cpu_hold && n < 50) begin tick(1); n++; end
    check("hold_release_bound", 64'(n < 50), 64'd1);
    tick(3);
    model_end();
  endtask

  task automatic cpu_read(input logic [11:0] a, output int lat);
    rq.push_back(shadow[a]);
    cpu_addr = a; cpu_req = 1'b1; lat = 0;
    do begin tick(1); lat++; end while (!cpu_ack && lat < 100);
    check("cpu_ack_bound", 64'(lat < 100), 64'd1);
    cpu_req = 1'b0;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int acks;
    reset_n = 1'b0; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_req = 0; cpu_addr = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    m_act = 0; m_len = 0; m_ovf = 0; m_sum = 0; m_loaded = 0;

    // Preload RAM under reset.
    for (int i = 0; i < 4096; i++) begin
      bd_we = 1'b1; bd_addr = 12'(i);
      bd_data = (i == 'h123) ? 8'h5A : 8'($urandom);
      shadow[i] = bd_data;
      tick(1);
    end
    bd_we = 1'b0;
    check("reset_outputs", outs(), 64'd0);

    // Release with a read already pending: no RAM access for two edges.
    reset_n = 1'b1;
    cpu_addr = 12'h123; cpu_req = 1'b1; rq.push_back(8'h5A);
    tick(1); check("no_access_edge1", 64'(ram_en), 64'd0);
    tick(1); check("no_access_edge2", 64'(ram_en), 64'd0);
    n = 0;
    while (!cpu_ack && n < 20) begin tick(1); n++; end
    check("first_read_bound", 64'(n < 20), 64'd1);
    cpu_req = 1'b0; tick(1);

    // Plain read: ack on the third cycle.
    cpu_read(12'h123, lat);
    check("read_latency", 64'(lat), 64'd3);

    // Four-byte download with write-latency measurement.
    dl_start(CART_IDX);
    check("hold_on_start", 64'(cpu_hold), 64'd1);
    ioctl_addr = 25'd0; ioctl_dout = 8'h01; ioctl_wr = 1'b1; model_push(25'd0, 8'h01);
    tick(1); ioctl_wr = 1'b0; lat = 1;
    while (!ram_we && lat < 10) begin tick(1); lat++; end
    check("write_latency", 64'(lat), 64'd2);
    dl_byte(25'd1, 8'h02); dl_byte(25'd2, 8'h03); dl_byte(25'd3, 8'h04);
    dl_end();
    check("dl4_status", status(), 64'({1'b1, 12'd4, 1'b0, SUM4}));
    check("dl4_hold_low", 64'(cpu_hold), 64'd0);

    // Read pending at the download's rising edge still completes.
    cpu_addr = 12'h200; cpu_req = 1'b1; rq.push_back(shadow[12'h200]);
    ioctl_index = CART_IDX; ioctl_download = 1'b1; model_begin(CART_IDX);
    lat = 0;
    do begin tick(1); lat++; end while (!cpu_ack && lat < 20);
    check("read_at_dl_start_lat", 64'(lat), 64'd3);
    cpu_req = 1'b0;
    check("hold_after_start_read", 64'(cpu_hold), 64'd1);
    dl_byte(25'h10, 8'h55);
    dl_end();
    check("dl_start_read_status", status(), exp_status());

    // Same-cycle write and read during a download: write first, read blocked.
    dl_start(CART_IDX);
    ioctl_addr = 25'd0; ioctl_dout = 8'h77; ioctl_wr = 1'b1; model_push(25'd0, 8'h77);
    cpu_addr = 12'h400; cpu_req = 1'b1; rq.push_back(shadow[12'h400]);
    tick(1); ioctl_wr = 1'b0;
    check("conflict_wait_high", 64'(ioctl_wait), 64'd1);
    tick(1);
    check("conflict_wait_low", 64'(ioctl_wait), 64'd0);
    check("conflict_write_first", 64'(ram_we), 64'd1);
    acks = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (cpu_ack) acks++; end
    check("conflict_read_blocked", 64'(acks), 64'd0);
    ioctl_download = 1'b0;
    n = 0;
    while (!cpu_ack && n < 20) begin tick(1); n++; end
    check("conflict_read_done", 64'(n < 20), 64'd1);
    cpu_req = 1'b0;
    tick(4); model_end();
    check("conflict_status", status(), exp_status());

    // Out-of-range byte: dropped, overflow flagged, not loaded.
    dl_start(CART_IDX);
    dl_byte(25'd3072, 8'hFF);
    dl_end();
    check("ovf_status", status(), 64'({1'b0, 12'd0, 1'b1, 8'h00}));

    // Foreign index: ignored entirely.
    dl_start(8'd2);
    for (int i = 0; i < 8; i++) begin
      dl_byte(25'(i), 8'($urandom));
      check("foreign_hold_low", 64'(cpu_hold), 64'd0);
    end
    dl_end();
    check("foreign_status_kept", status(), 64'({1'b0, 12'd0, 1'b1, 8'h00}));

    // Randomized downloads and reads.
    for (int t = 0; t < 10; t++) begin
      logic [24:0] off;
      dl_start(($urandom_range(0, 4) == 0) ? 8'd3 : CART_IDX);
      for (int b = 0; b < int'($urandom_range(1, 10)); b++) begin
        off = ($urandom_range(0, 9) == 0) ? 25'(3072 + $urandom_range(0, 200))
                                          : 25'($urandom_range(0, 3071));
        dl_byte(off, 8'($urandom));
      end
      dl_end();
      check("rand_status", status(), exp_status());
      for (int r = 0; r < 3; r++) begin
        cpu_read(($urandom_range(0, 1) == 0) ? 12'($urandom_range(12'h400, 12'hFFF))
                                             : 12'($urandom), lat);
        check("rand_read_latency", 64'(lat), 64'd3);
      end
    end

    // Reset during the write stage: no pulse survives, nothing written later.
    dl_start(CART_IDX);
    ioctl_addr = 25'd5; ioctl_dout = 8'hAB; ioctl_wr = 1'b1;
    tick(1); ioctl_wr = 1'b0;
    tick(1);
    check("pre_reset_in_write", 64'(ram_we), 64'd1);
    #1 reset_n = 1'b0;
    #1 check("reset_mid_write_outputs", outs(), 64'd0);
    ioctl_download = 1'b0; m_act = 0;
    m_len = 0; m_ovf = 0; m_sum = 0; m_loaded = 0;
    tick(3);
    reset_n = 1'b1;
    tick(10);
    check("no_write_after_reset", 64'(ram[12'h405]), 64'(shadow[12'h405]));
    check("status_after_reset", status(), exp_status());

    tick(2);
    check("write_queue_empty", 64'(wq.size()), 64'd0);
    check("read_queue_empty", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
